crack_par: RTL and testbench
============================

# crack_par

Parametrised RC4 key-search controller, successor to the single-instance `crack` block. It iterates candidate keys over a configurable slice of the key space (start and stride), drives an external ARC4 decrypt engine per key and scans the length-prefixed plaintext it produces for an allowed character range. Several instances with distinct `KEY_START` and a common `KEY_STRIDE` share a key space in parallel; `stop` lets a top-level arbiter abort the others once one instance succeeds.

## Interface
- `KEY_BITS`, 24: key width; search space 0 .. 2^KEY_BITS-1.
- `KEY_START`, 0: first key tested.
- `KEY_STRIDE`, 1: key increment between candidates (≥1).
- `CHAR_LO`, 8'h20: lowest accepted plaintext byte.
- `CHAR_HI`, 8'h7E: highest accepted plaintext byte.

- `clk`  in  1  clock; all logic on rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `en`  in  1  start request; honoured only while `rdy`=1.
- `stop`  in  1  abort request while busy.
- `rdy`  out  1  idle, ready to accept `en`.
- `key`  out  KEY_BITS  key under test / result key.
- `key_valid`  out  1  last search ended with a key found.
- `exhausted`  out  1  last search ended with no key in slice.
- `a_en`  out  1  one-cycle start pulse to ARC4 engine.
- `a_rdy`  in  1  ARC4 engine idle/done.
- `a_key`  out  KEY_BITS  key presented to ARC4; equals `key`.
- `pt_addr`  out  8  plaintext memory read address.
- `pt_rddata`  in  8  plaintext read data, 1-cycle latency.

## Operation
- States: IDLE, START, ARM, WAIT, RDLEN, SCAN, NEXT, FOUND, DONE.
- IDLE: `rdy`=1. On `en`: `key`←KEY_START, clear `key_valid`/`exhausted`, go START.
- START: hold until `a_rdy`=1, then assert `a_en` for exactly one cycle with `a_key`=`key`; go ARM.
- ARM: one dead cycle (engine drops `a_rdy`); go WAIT.
- WAIT: remain until `a_rdy`=1; go RDLEN.
- RDLEN: drive `pt_addr`=0; next cycle capture `len`=`pt_rddata`. `len`=0 → FOUND (empty message accepted). Else go SCAN.
- SCAN: pipelined; address i issued cycle t, byte checked cycle t+1, i=1..len, one byte/cycle. Byte outside [CHAR_LO, CHAR_HI] → NEXT immediately (remaining reads discarded). Byte `len` passes → FOUND.
- NEXT: compute `key`+KEY_STRIDE in KEY_BITS+1 bits; carry out (exceeds 2^KEY_BITS-1) → DONE, `key` unchanged; else `key`←sum, go START.
- FOUND: `key_valid`←1, `key` holds winning key; go IDLE.
- DONE: `exhausted`←1, `key` holds last tested key; go IDLE.
- `stop` (any busy state): in START, NEXT, RDLEN, SCAN → IDLE next cycle; in ARM/WAIT → finish waiting for `a_rdy`=1, then IDLE (never abandon engine mid-run). Abort leaves `key_valid`=0, `exhausted`=0. `stop` wins over a simultaneous pass/fail decision.
- `en` while busy ignored. `stop` while IDLE ignored.
- `key_valid` and `exhausted` never both 1; both hold until next accepted `en` or reset.

## Timing
- Reset (synchronous, `rst_n`=0 at edge): state IDLE, `rdy`=1, `key`=0, `key_valid`=0, `exhausted`=0, `a_en`=0, `pt_addr`=0. Reset mid-search aborts immediately; engine result ignored.
- `rdy` drops the cycle after `en` accepted; rises the cycle after FOUND/DONE/abort, same cycle flags update.
- Per-key overhead excluding engine run: START(≥1)+ARM(1)+WAIT exit(1)+RDLEN(2)+SCAN(≤len+1)+NEXT(1).
- `a_en` never asserted while `a_rdy`=0; never two consecutive cycles.
- `pt_addr` wraps never: max address 255 (len ≤255).

## Test plan
- Reset: hold `rst_n`=0 two edges → `rdy`=1, `key_valid`=0, `exhausted`=0, `key`=0, `a_en`=0.
- Default params, ARC4 model where only key 24'h000001 yields printable 53-byte message → one `a_en` per key 0 then 1; key 0 rejected at first bad byte; ends `key`=24'h000001, `key_valid`=1, `rdy`=1.
- KEY_START=1, KEY_STRIDE=2, same model → first `a_key`=1, found after one engine run; KEY_START=0, STRIDE=2, KEY_BITS=4 → keys 0,2,..,14 tried, `exhausted`=1, `key`=14.
- Message len=0 at key 5 (KEY_START=5) → `key_valid`=1 immediately after RDLEN, no SCAN reads.
- Boundary bytes: plaintext contains 8'h20 and 8'h7E → accepted; single 8'h7F at last position → rejected, key advances.
- `stop` asserted mid-SCAN → IDLE next cycle, flags 0; `stop` in WAIT → no return to IDLE until `a_rdy`=1; `en` during busy → no effect.

Source files
------------

// File: rtl/crack_par.sv
// crack_par: strided RC4 key-search controller. It starts an external ARC4
// engine per candidate key and scans the length-prefixed plaintext for bytes in range.
module crack_par #(
  parameter int         KEY_BITS   = 24,
  parameter int         KEY_START  = 0,
  parameter int         KEY_STRIDE = 1,
  parameter logic [7:0] CHAR_LO    = 8'h20,
  parameter logic [7:0] CHAR_HI    = 8'h7E
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                stop,
  output logic                rdy,
  output logic [KEY_BITS-1:0] key,
  output logic                key_valid,
  output logic                exhausted,
  output logic                a_en,
  input  logic                a_rdy,
  output logic [KEY_BITS-1:0] a_key,
  output logic [7:0]          pt_addr,
  input  logic [7:0]          pt_rddata
);

  typedef enum logic [3:0] {
    IDLE, START, ARM, WAIT, RDLEN, SCAN, NEXT, FOUND, DONE
  } state_t;

  state_t            state, next_state;
  logic [7:0]        len;
  logic [8:0]        cnt;
  logic              rd_ph;
  logic              stop_pend;
  logic [KEY_BITS:0] sum;
  logic              carry;
  logic              byte_ok;

  assign sum     = {1'b0, key} + (KEY_BITS+1)'(KEY_STRIDE);
  assign carry   = sum[KEY_BITS];
  assign byte_ok = (pt_rddata >= CHAR_LO) && (pt_rddata <= CHAR_HI);
  assign a_key   = key;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // cnt is the address issued this SCAN cycle; the byte being checked is cnt-1.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (en) next_state = START;
      START: begin
        if (stop)       next_state = IDLE;
        else if (a_rdy) next_state = ARM;
      end
      ARM:   next_state = WAIT;
      WAIT:  if (a_rdy) next_state = (stop_pend || stop) ? IDLE : RDLEN;
      RDLEN: begin
        if (stop)       next_state = IDLE;
        else if (rd_ph) next_state = (pt_rddata == 8'd0) ? FOUND : SCAN;
      end
      SCAN: begin
        if (stop)                                next_state = IDLE;
        else if (cnt >= 9'd2 && !byte_ok)        next_state = NEXT;
        else if (cnt == {1'b0, len} + 9'd1)      next_state = FOUND;
      end
      NEXT: begin
        if (stop)       next_state = IDLE;
        else if (carry) next_state = DONE;
        else            next_state = START;
      end
      FOUND:   next_state = IDLE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // A stop seen while the engine runs is remembered so the engine is never abandoned.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      key       <= '0;
      key_valid <= 1'b0;
      exhausted <= 1'b0;
      len       <= 8'd0;
      cnt       <= 9'd0;
      rd_ph     <= 1'b0;
      stop_pend <= 1'b0;
    end else begin
      rd_ph <= (state == RDLEN) && (next_state == RDLEN);
      case (state)
        IDLE: begin
          stop_pend <= 1'b0;
          if (en) begin
            key       <= KEY_BITS'(KEY_START);
            key_valid <= 1'b0;
            exhausted <= 1'b0;
          end
        end
        ARM, WAIT: if (stop) stop_pend <= 1'b1;
        RDLEN: begin
          if (rd_ph) begin
            len <= pt_rddata;
            cnt <= 9'd1;
          end
        end
        SCAN:  cnt <= cnt + 9'd1;
        NEXT:  if (!stop && !carry) key <= sum[KEY_BITS-1:0];
        FOUND: key_valid <= 1'b1;
        DONE:  exhausted <= 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    rdy     = (state == IDLE);
    a_en    = 1'b0;
    pt_addr = 8'd0;
    if (state == START && a_rdy && !stop && rst_n) a_en = 1'b1;
    if (state == SCAN && cnt <= {1'b0, len})       pt_addr = cnt[7:0];
  end

endmodule

// File: tb/tb_crack_par.sv
// Bench for crack_par: three parameter sets share an ARC4/plaintext model and
// a reference predictor that walks the key slice directly.
`timescale 1ns/1ps
module tb_crack_par;

  localparam int NI = 3;
  localparam int KB[NI]     = '{24, 4, 4};
  localparam int KSTART[NI] = '{0, 0, 5};
  localparam int KSTEP[NI]  = '{1, 2, 3};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [NI-1:0] en, stop, rdy, key_valid, exhausted, a_en, a_rdy, hold;
  logic [23:0]   key_a, a_key_a;
  logic [3:0]    key_b, a_key_b, key_c, a_key_c;
  logic [7:0]    pt_addr_a, pt_addr_b, pt_addr_c;
  logic [23:0]   key_w [NI];
  logic [23:0]   a_key_w [NI];
  logic [7:0]    pt_addr [NI];
  logic [7:0]    pt_rddata [NI];
  logic [7:0]    mem [NI][256];
  int            run [NI];

  crack_par dut_a (
    .clk(clk), .rst_n(rst_n), .en(en[0]), .stop(stop[0]), .rdy(rdy[0]),
    .key(key_a), .key_valid(key_valid[0]), .exhausted(exhausted[0]),
    .a_en(a_en[0]), .a_rdy(a_rdy[0]), .a_key(a_key_a),
    .pt_addr(pt_addr_a), .pt_rddata(pt_rddata[0]));

  crack_par #(.KEY_BITS(4), .KEY_START(0), .KEY_STRIDE(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en[1]), .stop(stop[1]), .rdy(rdy[1]),
    .key(key_b), .key_valid(key_valid[1]), .exhausted(exhausted[1]),
    .a_en(a_en[1]), .a_rdy(a_rdy[1]), .a_key(a_key_b),
    .pt_addr(pt_addr_b), .pt_rddata(pt_rddata[1]));

  crack_par #(.KEY_BITS(4), .KEY_START(5), .KEY_STRIDE(3)) dut_c (
    .clk(clk), .rst_n(rst_n), .en(en[2]), .stop(stop[2]), .rdy(rdy[2]),
    .key(key_c), .key_valid(key_valid[2]), .exhausted(exhausted[2]),
    .a_en(a_en[2]), .a_rdy(a_rdy[2]), .a_key(a_key_c),
    .pt_addr(pt_addr_c), .pt_rddata(pt_rddata[2]));

  assign key_w[0]   = key_a;
  assign key_w[1]   = {20'd0, key_b};
  assign key_w[2]   = {20'd0, key_c};
  assign a_key_w[0] = a_key_a;
  assign a_key_w[1] = {20'd0, a_key_b};
  assign a_key_w[2] = {20'd0, a_key_c};
  assign pt_addr[0] = pt_addr_a;
  assign pt_addr[1] = pt_addr_b;
  assign pt_addr[2] = pt_addr_c;

  int         checks = 0;
  int         errors = 0;
  bit         started = 0;
  logic [15:0] good_mask [NI];
  int         force_len [NI];
  int         force_run [NI];
  bit         force_bad_last [NI];
  bit         aborting [NI];

  task automatic checkOutput(input string name, input int idx,
                             input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s[%0d]: got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  function automatic bit is_good(input int i, input logic [23:0] k);
    return (k < 24'd16) ? good_mask[i][k[3:0]] : 1'b0;
  endfunction

  // Walk the key slice from the start key until a good key or the top of the space.
  function automatic void predict(input int i, output bit found,
                                  output logic [23:0] fkey, output int tries);
    longint k, maxk;
    k = KSTART[i];
    maxk = (longint'(1) << KB[i]) - 1;
    found = 0; fkey = '0; tries = 0;
    for (int n = 0; n < 100000; n++) begin
      tries++;
      if (is_good(i, 24'(k))) begin found = 1; fkey = 24'(k); return; end
      if (k + KSTEP[i] > maxk) begin fkey = 24'(k); return; end
      k += KSTEP[i];
    end
  endfunction

  // ARC4 engine stand-in: busy for a few cycles after each start, plaintext RAM with 1-cycle read.
  always_comb begin
    for (int i = 0; i < NI; i++) a_rdy[i] = (run[i] == 0) && !hold[i];
  end

  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      pt_rddata[i] <= mem[i][pt_addr[i]];
      if (!rst_n)                   run[i] <= 0;
      else if (a_en[i] && a_rdy[i]) run[i] <= (force_run[i] != 0) ? force_run[i] : int'($urandom_range(1, 6));
      else if (run[i] != 0)         run[i] <= run[i] - 1;
    end
  end

  int          n_aen [NI];
  logic [23:0] exp_next [NI];
  int          exp_max [NI];
  int          max_addr [NI];
  bit          has_prev [NI], active [NI], just_acc [NI], prev_aen [NI], prev_rdy [NI];

  always @(negedge clk) begin
    int mlen, p, tries;
    bit good, found;
    logic [23:0] fkey;
    logic [7:0] bad;
    for (int i = 0; i < NI; i++) begin
      if (!rst_n) begin
        active[i] = 0; has_prev[i] = 0; prev_aen[i] = 0; prev_rdy[i] = 1; just_acc[i] = 0;
      end else if (started) begin
        checkOutput("aen_when_rdy", i, a_en[i] ? a_rdy[i] : 1'b1, 1);
        checkOutput("aen_twice", i, prev_aen[i] & a_en[i], 0);
        checkOutput("flags_excl", i, key_valid[i] & exhausted[i], 0);
        checkOutput("idle_engine_busy", i, rdy[i] & (run[i] != 0), 0);
        checkOutput("akey_eq_key", i, a_key_w[i], key_w[i]);
        if (just_acc[i]) checkOutput("rdy_drop", i, rdy[i], 0);
        just_acc[i] = 0;
        if (int'(pt_addr[i]) > max_addr[i]) max_addr[i] = pt_addr[i];
        if (a_en[i]) begin
          if (has_prev[i]) checkOutput("scan_reads", i, max_addr[i], exp_max[i]);
          checkOutput("a_key", i, a_key_w[i], exp_next[i]);
          exp_next[i] = exp_next[i] + 24'(KSTEP[i]);
          n_aen[i]++;
          good = is_good(i, a_key_w[i]);
          if (force_len[i] >= 0)                  mlen = force_len[i];
          else if (good && $urandom_range(0, 3) == 0) mlen = 0;
          else                                    mlen = $urandom_range(1, 60);
          if (!good && mlen == 0) mlen = 1;
          mem[i][0] = 8'(mlen);
          for (int j = 1; j <= mlen; j++) mem[i][j] = 8'($urandom_range(32, 126));
          if (mlen < 255) mem[i][mlen+1] = 8'h00;
          if (mlen >= 2) begin mem[i][1] = 8'h20; mem[i][mlen] = 8'h7E; end
          if (good) exp_max[i] = mlen;
          else begin
            p = (force_bad_last[i] || $urandom_range(0, 2) == 0) ? mlen : int'($urandom_range(1, mlen));
            case ($urandom_range(0, 3))
              0: bad = 8'h7F;
              1: bad = 8'h1F;
              2: bad = 8'h00;
              default: bad = 8'hFF;
            endcase
            if (force_bad_last[i]) bad = 8'h7F;
            mem[i][p] = bad;
            exp_max[i] = (p < mlen) ? p + 1 : mlen;
          end
          max_addr[i] = 0;
          has_prev[i] = 1;
        end
        if (active[i] && rdy[i] && !prev_rdy[i]) begin
          active[i] = 0;
          if (aborting[i]) begin
            checkOutput("abort_kv", i, key_valid[i], 0);
            checkOutput("abort_ex", i, exhausted[i], 0);
          end else begin
            if (has_prev[i]) checkOutput("scan_reads", i, max_addr[i], exp_max[i]);
            predict(i, found, fkey, tries);
            checkOutput("key_valid", i, key_valid[i], found);
            checkOutput("exhausted", i, exhausted[i], !found);
            checkOutput("result_key", i, key_w[i], fkey);
            checkOutput("engine_runs", i, n_aen[i], tries);
          end
          has_prev[i] = 0;
        end
        if (rdy[i] && en[i]) begin
          active[i] = 1; just_acc[i] = 1; n_aen[i] = 0;
          exp_next[i] = 24'(KSTART[i]); has_prev[i] = 0;
        end
        prev_aen[i] = a_en[i];
        prev_rdy[i] = rdy[i];
      end
    end
  end

  // One search on instance i; stop_mode 1 aborts mid-SCAN, 2 aborts while the engine runs.
  task automatic applyStimulus(input int i, input logic [15:0] mask, input int flen,
                               input int frun, input int stop_mode, input bit bad_last,
                               input bit spurious, input int hold_cycles);
    int c, sent_at;
    bit fin, sent;
    good_mask[i] = mask; force_len[i] = flen; force_run[i] = frun;
    force_bad_last[i] = bad_last; aborting[i] = 0;
    c = 0; fin = 0; sent = 0; sent_at = -10;
    @(posedge clk); #1;
    en[i] = 1'b1;
    hold[i] = (hold_cycles > 0);
    while (!fin && c < 20000) begin
      @(posedge clk); #1;
      c++;
      stop[i] = 1'b0;
      if (c == hold_cycles) hold[i] = 1'b0;
      en[i] = (spurious && c == 3 && !rdy[i]);
      if (sent && sent_at == c - 1) begin
        if (stop_mode == 1) checkOutput("stop_scan_idle", i, rdy[i], 1);
        else                checkOutput("stop_wait_busy", i, rdy[i], 0);
      end
      if (rdy[i]) fin = 1;
      else if (!sent && stop_mode == 1 && pt_addr[i] >= 8'd3) begin
        aborting[i] = 1; stop[i] = 1'b1; sent = 1; sent_at = c;
      end else if (!sent && stop_mode == 2 && run[i] > 3) begin
        aborting[i] = 1; stop[i] = 1'b1; sent = 1; sent_at = c;
      end
    end
    if (!fin) checkOutput("search_timeout", i, rdy[i], 1);
    en[i] = 1'b0; stop[i] = 1'b0; hold[i] = 1'b0;
    @(negedge clk); #1;
  endtask

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int idx;
    logic [15:0] m;
    rst_n = 1'b0; en = '0; stop = '0; hold = '0;
    for (int i = 0; i < NI; i++) begin
      good_mask[i] = '0; force_len[i] = -1; force_run[i] = 0;
      force_bad_last[i] = 0; aborting[i] = 0;
      for (int j = 0; j < 256; j++) mem[i][j] = 8'h00;
    end
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_rdy", 0, rdy[0], 1);
    checkOutput("reset_kv", 0, key_valid[0], 0);
    checkOutput("reset_ex", 0, exhausted[0], 0);
    checkOutput("reset_key", 0, key_a, 24'h000000);
    checkOutput("reset_aen", 0, a_en[0], 0);
    checkOutput("reset_addr", 0, pt_addr_a, 8'h00);
    checkOutput("reset_key", 2, key_c, 4'h0);
    rst_n = 1'b1;
    started = 1;

    stop[0] = 1'b1;
    @(posedge clk); #1;
    stop[0] = 1'b0;
    checkOutput("stop_idle_ignored", 0, rdy[0], 1);

    $display("[TB] key 1 wins after key 0 fails on its last byte");
    applyStimulus(0, 16'h0002, 53, 0, 0, 1, 0, 0);
    checkOutput("lit_key1", 0, key_a, 24'h000001);
    checkOutput("lit_key1_kv", 0, key_valid[0], 1);
    checkOutput("lit_key1_runs", 0, n_aen[0], 2);

    $display("[TB] stride 2 over 4-bit space, nothing good");
    applyStimulus(1, 16'h0000, -1, 0, 0, 0, 0, 2);
    checkOutput("lit_exh_key", 1, key_b, 4'hE);
    checkOutput("lit_exh_ex", 1, exhausted[1], 1);
    checkOutput("lit_exh_runs", 1, n_aen[1], 8);

    $display("[TB] empty message at start key 5");
    applyStimulus(2, 16'h0020, 0, 0, 0, 0, 0, 0);
    checkOutput("lit_len0_key", 2, key_c, 4'h5);
    checkOutput("lit_len0_kv", 2, key_valid[2], 1);

    applyStimulus(2, 16'h0000, -1, 0, 0, 0, 0, 0);
    checkOutput("lit_c_exh_key", 2, key_c, 4'hE);

    $display("[TB] abort during SCAN and during engine run");
    applyStimulus(0, 16'h0001, 200, 0, 1, 0, 0, 0);
    checkOutput("lit_abort_kv", 0, key_valid[0], 0);
    applyStimulus(0, 16'h0001, 10, 20, 2, 0, 0, 0);
    checkOutput("lit_abort_runs", 0, n_aen[0], 1);

    applyStimulus(0, 16'h0004, -1, 0, 0, 0, 1, 3);
    checkOutput("lit_busy_en_key", 0, key_a, 24'h000002);

    $display("[TB] reset in the middle of a search");
    good_mask[2] = 16'h0020; force_len[2] = 200; force_run[2] = 2; aborting[2] = 0;
    @(posedge clk); #1 en[2] = 1'b1;
    @(posedge clk); #1 en[2] = 1'b0;
    repeat (30) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    checkOutput("midrst_rdy", 2, rdy[2], 1);
    checkOutput("midrst_key", 2, key_c, 4'h0);
    checkOutput("midrst_kv", 2, key_valid[2], 0);
    rst_n = 1'b1;

    $display("[TB] randomized searches");
    for (int n = 0; n < 45; n++) begin
      idx = $urandom_range(0, NI - 1);
      if (idx == 0) m = 16'($urandom_range(0, 255)) | (16'h0001 << $urandom_range(0, 7));
      else          m = 16'($urandom) & 16'($urandom) & 16'($urandom);
      applyStimulus(idx, m, -1, 0, ($urandom_range(0, 5) == 0) ? 1 : 0, 0,
                    ($urandom_range(0, 3) == 0), $urandom_range(0, 4));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
